blackparrot_fpga_host_write_arbiter: RTL and testbench

//  Shares one AXIL write master port among REQ_ELS_P FIFO-style requesters.

---
 rtl/blackparrot_fpga_host_write_arbiter_if.sv | 29 ++
 rtl/blackparrot_fpga_host_write_arbiter.sv | 160 ++++++++++++++++
 tb/tb_blackparrot_fpga_host_write_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/blackparrot_fpga_host_write_arbiter_if.sv
// AXI-Lite write-channel bundle (AW, W, B) between the host write arbiter and a CSR slave.
interface blackparrot_fpga_host_write_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   m_axil_awaddr;
    logic                m_axil_awvalid;
    logic                m_axil_awready;
    logic [2:0]          m_axil_awprot;
    logic [DATA_W-1:0]   m_axil_wdata;
    logic [DATA_W/8-1:0] m_axil_wstrb;
    logic                m_axil_wvalid;
    logic                m_axil_wready;
    logic                m_axil_bvalid;
    logic                m_axil_bready;
    logic [1:0]          m_axil_bresp;

    modport master (
        output m_axil_awaddr, m_axil_awvalid, m_axil_awprot,
        output m_axil_wdata, m_axil_wstrb, m_axil_wvalid, m_axil_bready,
        input  m_axil_awready, m_axil_wready, m_axil_bvalid, m_axil_bresp
    );

    modport slave (
        input  m_axil_awaddr, m_axil_awvalid, m_axil_awprot,
        input  m_axil_wdata, m_axil_wstrb, m_axil_wvalid, m_axil_bready,
        output m_axil_awready, m_axil_wready, m_axil_bvalid, m_axil_bresp
    );
endinterface

// File: rtl/blackparrot_fpga_host_write_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite write port among FIFO requesters, one write in flight.
// Optional error reporting on non-OKAY responses: define BP_FPGA_HOST_WRITE_ARB_ERR_EN.
module blackparrot_fpga_host_write_arbiter #(
    parameter int M_AXIL_ADDR_WIDTH = 64,
    parameter int M_AXIL_DATA_WIDTH = 32,
    parameter int REQ_ELS_P = 2,
    parameter logic [REQ_ELS_P-1:0][M_AXIL_ADDR_WIDTH-1:0] req_addr_p = '0,
    localparam int ID_W = (REQ_ELS_P > 1) ? $clog2(REQ_ELS_P) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [REQ_ELS_P-1:0]                   fifo_v_i,
    input  logic [REQ_ELS_P*M_AXIL_DATA_WIDTH-1:0] fifo_data_i,
    output logic [REQ_ELS_P-1:0]                   fifo_yumi_o,
    blackparrot_fpga_host_write_arbiter_if.master  m_axil,
`ifdef BP_FPGA_HOST_WRITE_ARB_ERR_EN
    output logic                                   err_v_o,
    output logic [ID_W-1:0]                        err_id_o,
`endif
    output logic                                   busy_o
);
    typedef enum logic [1:0] {e_ready, e_send, e_resp} state_e;

    state_e                       state_q, state_d;
    logic [ID_W-1:0]              ptr_q, ptr_d;
    logic [ID_W-1:0]              gnt_q, gnt_d;
    logic [M_AXIL_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [M_AXIL_DATA_WIDTH-1:0] data_q, data_d;
    logic                         awvalid_q, awvalid_d;
    logic                         wvalid_q, wvalid_d;
    logic                         bready_q, bready_d;

    logic                         gnt_found;
    logic [ID_W-1:0]              gnt_id;
    logic [ID_W-1:0]              cand;
    logic [M_AXIL_DATA_WIDTH-1:0] data_sel;
    logic [REQ_ELS_P-1:0]         yumi;

    // Rotating priority search starting at the pointer.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int unsigned k = 0; k < REQ_ELS_P; k++) begin
            cand = ID_W'((32'(ptr_q) + k) % REQ_ELS_P);
            if (!gnt_found && fifo_v_i[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
        data_sel = '0;
        for (int unsigned i = 0; i < REQ_ELS_P; i++) begin
            if (ID_W'(i) == gnt_id) data_sel = fifo_data_i[i*M_AXIL_DATA_WIDTH +: M_AXIL_DATA_WIDTH];
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        yumi      = '0;
        case (state_q)
            e_ready: begin
                if (gnt_found) begin
                    yumi[gnt_id] = 1'b1;
                    gnt_d        = gnt_id;
                    addr_d       = req_addr_p[gnt_id];
                    data_d       = data_sel;
                    ptr_d        = (gnt_id == ID_W'(REQ_ELS_P - 1)) ? '0 : gnt_id + ID_W'(1);
                    awvalid_d    = 1'b1;
                    wvalid_d     = 1'b1;
                    state_d      = e_send;
                end
            end
            e_send: begin
                // A deasserted valid doubles as the channel's done flag.
                if (m_axil.m_axil_awready) awvalid_d = 1'b0;
                if (m_axil.m_axil_wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = e_resp;
                end
            end
            e_resp: begin
                if (m_axil.m_axil_bvalid) begin
                    bready_d = 1'b0;
                    state_d  = e_ready;
                end
            end
            default: state_d = e_ready;
        endcase
    end

`ifdef BP_FPGA_HOST_WRITE_ARB_ERR_EN
    logic            err_v_q, err_v_d;
    logic [ID_W-1:0] err_id_q, err_id_d;

    always_comb begin
        err_v_d  = 1'b0;
        err_id_d = err_id_q;
        if (state_q == e_resp && m_axil.m_axil_bvalid && m_axil.m_axil_bresp != 2'b00) begin
            err_v_d  = 1'b1;
            err_id_d = gnt_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_v_q  <= 1'b0;
            err_id_q <= '0;
        end else begin
            err_v_q  <= err_v_d;
            err_id_q <= err_id_d;
        end
    end

    assign err_v_o  = err_v_q;
    assign err_id_o = err_id_q;
`else
    logic unused_sink;
    assign unused_sink = ^{m_axil.m_axil_bresp, gnt_q};
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= e_ready;
            ptr_q     <= '0;
            gnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
        end
    end

    assign fifo_yumi_o           = yumi;
    assign busy_o                = (state_q != e_ready);
    assign m_axil.m_axil_awaddr  = addr_q;
    assign m_axil.m_axil_awvalid = awvalid_q;
    assign m_axil.m_axil_awprot  = 3'b000;
    assign m_axil.m_axil_wdata   = data_q;
    assign m_axil.m_axil_wstrb   = '1;
    assign m_axil.m_axil_wvalid  = wvalid_q;
    assign m_axil.m_axil_bready  = bready_q;
endmodule

// File: tb/tb_blackparrot_fpga_host_write_arbiter.sv
// Directed and randomized-stall bench for blackparrot_fpga_host_write_arbiter (two requesters).
module tb_blackparrot_fpga_host_write_arbiter;
    localparam logic [1:0][63:0] ADDRS = {64'h200, 64'h100};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  fifo_v = '0;
    logic [63:0] fifo_data = '0;
    logic [1:0]  yumi;
    logic        busy;
    int          checks = 0;
    int          failures = 0;
`ifdef BP_FPGA_HOST_WRITE_ARB_ERR_EN
    logic        err_v;
    logic [0:0]  err_id;
`endif

    blackparrot_fpga_host_write_arbiter_if #(.ADDR_W(64), .DATA_W(32)) axil ();

    blackparrot_fpga_host_write_arbiter #(
        .M_AXIL_ADDR_WIDTH(64),
        .M_AXIL_DATA_WIDTH(32),
        .REQ_ELS_P(2),
        .req_addr_p(ADDRS)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .fifo_v_i(fifo_v),
        .fifo_data_i(fifo_data),
        .fifo_yumi_o(yumi),
        .m_axil(axil),
`ifdef BP_FPGA_HOST_WRITE_ARB_ERR_EN
        .err_v_o(err_v),
        .err_id_o(err_id),
`endif
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fifo_v = '0;
        axil.m_axil_awready = 1'b0;
        axil.m_axil_wready = 1'b0;
        axil.m_axil_bvalid = 1'b0;
        axil.m_axil_bresp = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({axil.m_axil_awvalid, axil.m_axil_wvalid, axil.m_axil_bready, busy, yumi} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got aw=%b w=%b b=%b busy=%b yumi=%b expected all 0",
                     axil.m_axil_awvalid, axil.m_axil_wvalid, axil.m_axil_bready, busy, yumi);
        end
        checks++;
        if ({axil.m_axil_awprot, axil.m_axil_wstrb} !== {3'b000, 4'hF}) begin
            failures++;
            $display("FAIL const_prot_strb got prot=%b strb=%h expected 000/f", axil.m_axil_awprot, axil.m_axil_wstrb);
        end
        step();
    endtask

    task automatic test_single_write();
        fifo_v = 2'b01;
        fifo_data[31:0] = 32'hDEAD_BEEF;
        axil.m_axil_awready = 1'b1;
        axil.m_axil_wready = 1'b1;
        @(negedge clk);
        checks++;
        if ({yumi, busy, axil.m_axil_awvalid} !== 4'b0100) begin
            failures++;
            $display("FAIL single_grant got yumi=%b busy=%b awv=%b expected 01/0/0", yumi, busy, axil.m_axil_awvalid);
        end
        step();
        fifo_v = 2'b00;
        @(negedge clk);
        checks++;
        if ({axil.m_axil_awvalid, axil.m_axil_wvalid, busy, yumi} !== 5'b11100) begin
            failures++;
            $display("FAIL single_send_ctrl got aw=%b w=%b busy=%b yumi=%b expected 1/1/1/00",
                     axil.m_axil_awvalid, axil.m_axil_wvalid, busy, yumi);
        end
        checks++;
        if ({axil.m_axil_awaddr, axil.m_axil_wdata} !== {64'h100, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL single_addr_data got %h/%h expected 100/deadbeef", axil.m_axil_awaddr, axil.m_axil_wdata);
        end
        step();
        @(negedge clk);
        checks++;
        if ({axil.m_axil_bready, axil.m_axil_awvalid, axil.m_axil_wvalid} !== 3'b100) begin
            failures++;
            $display("FAIL single_resp1 got b=%b aw=%b w=%b expected 1/0/0",
                     axil.m_axil_bready, axil.m_axil_awvalid, axil.m_axil_wvalid);
        end
        step();
        axil.m_axil_bvalid = 1'b1;
        @(negedge clk);
        checks++;
        if ({axil.m_axil_bready, busy} !== 2'b11) begin
            failures++;
            $display("FAIL single_resp_hold got bready=%b busy=%b expected 1/1", axil.m_axil_bready, busy);
        end
        step();
        axil.m_axil_bvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({axil.m_axil_bready, busy} !== 2'b00) begin
            failures++;
            $display("FAIL single_done got bready=%b busy=%b expected 0/0", axil.m_axil_bready, busy);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d;
        do_reset();
        fifo_data = {32'hB000_0001, 32'hA000_0000};
        fifo_v = 2'b11;
        axil.m_axil_awready = 1'b1;
        axil.m_axil_wready = 1'b1;
        axil.m_axil_bvalid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_d = (k % 2 == 0) ? 32'hA000_0000 : 32'hB000_0001;
            @(negedge clk);
            checks++;
            if ({yumi, busy} !== {2'(1 << (k % 2)), 1'b0}) begin
                failures++;
                $display("FAIL b2b_grant%0d got yumi=%b busy=%b expected %b/0", k, yumi, busy, 2'(1 << (k % 2)));
            end
            step();
            @(negedge clk);
            checks++;
            if ({axil.m_axil_awvalid, axil.m_axil_wvalid, axil.m_axil_awaddr, axil.m_axil_wdata}
                !== {2'b11, ADDRS[k % 2], exp_d}) begin
                failures++;
                $display("FAIL b2b_send%0d got aw=%b w=%b addr=%h data=%h expected 1/1/%h/%h", k,
                         axil.m_axil_awvalid, axil.m_axil_wvalid, axil.m_axil_awaddr, axil.m_axil_wdata,
                         ADDRS[k % 2], exp_d);
            end
            step();
            @(negedge clk);
            checks++;
            if ({axil.m_axil_bready, yumi} !== 3'b100) begin
                failures++;
                $display("FAIL b2b_resp%0d got bready=%b yumi=%b expected 1/00", k, axil.m_axil_bready, yumi);
            end
            step();
        end
        fifo_v = 2'b00;
        axil.m_axil_bvalid = 1'b0;
    endtask

    // Delays one channel's ready by four cycles while the other accepts at once.
    task automatic delayed_ready(input int req, input bit delay_aw);
        logic [31:0] exp_d;
        exp_d = (req == 0) ? 32'h1111_0000 : 32'h2222_0001;
        fifo_data = {32'h2222_0001, 32'h1111_0000};
        fifo_v = 2'(1 << req);
        @(negedge clk);
        step();
        fifo_v = 2'b00;
        for (int s = 0; s < 5; s++) begin
            axil.m_axil_awready = delay_aw ? (s == 4) : 1'b1;
            axil.m_axil_wready  = delay_aw ? 1'b1 : (s == 4);
            @(negedge clk);
            checks++;
            if ({axil.m_axil_awvalid, axil.m_axil_wvalid, axil.m_axil_awaddr, axil.m_axil_wdata, axil.m_axil_bready}
                !== {delay_aw ? 1'b1 : (s == 0), delay_aw ? (s == 0) : 1'b1, ADDRS[req], exp_d, 1'b0}) begin
                failures++;
                $display("FAIL stall_aw%0d_s%0d got aw=%b w=%b addr=%h data=%h bready=%b", delay_aw, s,
                         axil.m_axil_awvalid, axil.m_axil_wvalid, axil.m_axil_awaddr, axil.m_axil_wdata,
                         axil.m_axil_bready);
            end
            step();
        end
        axil.m_axil_awready = 1'b1;
        axil.m_axil_wready = 1'b1;
        axil.m_axil_bvalid = 1'b1;
        @(negedge clk);
        checks++;
        if ({axil.m_axil_bready, axil.m_axil_awvalid, axil.m_axil_wvalid} !== 3'b100) begin
            failures++;
            $display("FAIL stall_resp_aw%0d got b=%b aw=%b w=%b expected 1/0/0", delay_aw,
                     axil.m_axil_bready, axil.m_axil_awvalid, axil.m_axil_wvalid);
        end
        step();
        axil.m_axil_bvalid = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        delayed_ready(0, 1'b1);
        delayed_ready(1, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int ph = 0; ph < 2; ph++) begin
            do_reset();
            fifo_v = 2'b01;
            axil.m_axil_awready = (ph == 1);
            axil.m_axil_wready = (ph == 1);
            @(negedge clk);
            step();
            fifo_v = 2'b00;
            if (ph == 1) step();
            reset = 1'b1;
            step();
            reset = 1'b0;
            @(negedge clk);
            checks++;
            if ({axil.m_axil_awvalid, axil.m_axil_wvalid, axil.m_axil_bready, busy, yumi} !== 6'b0) begin
                failures++;
                $display("FAIL reset_mid%0d got aw=%b w=%b b=%b busy=%b yumi=%b expected all 0", ph,
                         axil.m_axil_awvalid, axil.m_axil_wvalid, axil.m_axil_bready, busy, yumi);
            end
            step();
            fifo_v = 2'b11;
            @(negedge clk);
            checks++;
            if (yumi !== 2'b01) begin
                failures++;
                $display("FAIL reset_mid%0d_ptr got yumi=%b expected 01", ph, yumi);
            end
            step();
            fifo_v = 2'b00;
        end
        do_reset();
    endtask

`ifdef BP_FPGA_HOST_WRITE_ARB_ERR_EN
    task automatic test_err();
        do_reset();
        axil.m_axil_awready = 1'b1;
        axil.m_axil_wready = 1'b1;
        for (int w = 0; w < 2; w++) begin
            fifo_v = (w == 0) ? 2'b10 : 2'b01;
            step();
            fifo_v = 2'b00;
            step();
            axil.m_axil_bvalid = 1'b1;
            axil.m_axil_bresp = (w == 0) ? 2'b10 : 2'b00;
            @(negedge clk);
            checks++;
            if (err_v !== 1'b0) begin
                failures++;
                $display("FAIL err_pre%0d got err_v=%b expected 0", w, err_v);
            end
            step();
            axil.m_axil_bvalid = 1'b0;
            axil.m_axil_bresp = 2'b00;
            @(negedge clk);
            checks++;
            if ({err_v, err_id} !== {(w == 0), 1'b1}) begin
                failures++;
                $display("FAIL err_pulse%0d got v=%b id=%b expected %b/1", w, err_v, err_id, (w == 0));
            end
            step();
            @(negedge clk);
            checks++;
            if ({err_v, err_id} !== 2'b01) begin
                failures++;
                $display("FAIL err_hold%0d got v=%b id=%b expected 0/1", w, err_v, err_id);
            end
        end
    endtask
`endif

    task automatic test_random();
        int          sent[2];
        int          obs[2];
        int          completed;
        int          cycles;
        int          r;
        bit          aw_seen;
        bit          w_seen;
        bit          aw_pend;
        logic [63:0] aw_a;
        logic [31:0] w_d;
        logic [63:0] pend_addr;
        sent = '{0, 0};
        obs = '{0, 0};
        completed = 0;
        cycles = 0;
        aw_seen = 0;
        w_seen = 0;
        aw_pend = 0;
        aw_a = '0;
        w_d = '0;
        pend_addr = '0;
        do_reset();
        while (completed < 1000 && cycles < 60000) begin
            for (int i = 0; i < 2; i++) begin
                fifo_v[i] = (sent[i] < 500) && ($urandom_range(0, 3) != 0);
                fifo_data[i*32 +: 32] = {4'(i), 28'(sent[i])};
            end
            axil.m_axil_awready = 1'($urandom_range(0, 1));
            axil.m_axil_wready = 1'($urandom_range(0, 1));
            axil.m_axil_bvalid = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            if (aw_pend) begin
                checks++;
                if (axil.m_axil_awvalid !== 1'b1 || axil.m_axil_awaddr !== pend_addr) begin
                    failures++;
                    $display("FAIL rand_aw_stable got v=%b addr=%h expected 1/%h",
                             axil.m_axil_awvalid, axil.m_axil_awaddr, pend_addr);
                end
            end
            aw_pend = axil.m_axil_awvalid && !axil.m_axil_awready;
            pend_addr = axil.m_axil_awaddr;
            if (yumi != 2'b00) begin
                checks++;
                if ((yumi & ~fifo_v) != 2'b00 || yumi == 2'b11) begin
                    failures++;
                    $display("FAIL rand_yumi got yumi=%b with fifo_v=%b", yumi, fifo_v);
                end
                for (int i = 0; i < 2; i++) if (yumi[i]) sent[i]++;
            end
            if (axil.m_axil_awvalid && axil.m_axil_awready) begin
                checks++;
                if (aw_seen) begin
                    failures++;
                    $display("FAIL rand_dup_aw got second AW handshake addr=%h", axil.m_axil_awaddr);
                end
                aw_seen = 1;
                aw_a = axil.m_axil_awaddr;
            end
            if (axil.m_axil_wvalid && axil.m_axil_wready) begin
                checks++;
                if (w_seen) begin
                    failures++;
                    $display("FAIL rand_dup_w got second W handshake data=%h", axil.m_axil_wdata);
                end
                w_seen = 1;
                w_d = axil.m_axil_wdata;
            end
            if (axil.m_axil_bvalid && axil.m_axil_bready) begin
                r = (aw_a == 64'h200) ? 1 : 0;
                checks++;
                if (!aw_seen || !w_seen || (aw_a !== 64'h100 && aw_a !== 64'h200)
                    || w_d !== {4'(r), 28'(obs[r])}) begin
                    failures++;
                    $display("FAIL rand_scoreboard got addr=%h data=%h aw=%b w=%b expected data=%h",
                             aw_a, w_d, aw_seen, w_seen, {4'(r), 28'(obs[r])});
                end
                obs[r]++;
                completed++;
                aw_seen = 0;
                w_seen = 0;
            end
            step();
            cycles++;
        end
        fifo_v = 2'b00;
        axil.m_axil_bvalid = 1'b0;
        checks++;
        if (completed != 1000 || obs[0] != 500 || obs[1] != 500 || sent[0] != 500 || sent[1] != 500) begin
            failures++;
            $display("FAIL rand_totals got completed=%0d obs=%0d/%0d sent=%0d/%0d expected 1000 500/500 500/500",
                     completed, obs[0], obs[1], sent[0], sent[1]);
        end
    endtask

    initial begin
        axil.m_axil_awready = 1'b0;
        axil.m_axil_wready = 1'b0;
        axil.m_axil_bvalid = 1'b0;
        axil.m_axil_bresp = 2'b00;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_stall();
        test_reset_mid();
`ifdef BP_FPGA_HOST_WRITE_ARB_ERR_EN
        test_err();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
